// File: rtl/mandelbrot_pkg.sv
// Shared types, constants and colour map for the multi-lane
// Mandelbrot renderer.
package mandelbrot_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } top_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_ITER,
    L_HOLD
  } lane_state_t;

  localparam int PKG_FRAC_W = 24;
  localparam int COORD_W    = 10;

  // 4.0 with PKG_FRAC_W fractional bits; lanes rescale to their FRAC_W
  localparam logic [63:0] ESCAPE_SQ = 64'd4 << PKG_FRAC_W;

  function automatic logic [23:0] colour_map(
    input logic [7:0] it8,
    input logic       at_max
  );
    return at_max ? 24'h000000 : {it8, ~it8, 8'hFF};
  endfunction

endpackage

// File: rtl/mandelbrot_lane.sv
// One escape-time iteration lane: loads a pixel constant, iterates
// z = z^2 + c until escape or the limit, then holds the result.
module mandelbrot_lane
  import mandelbrot_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24,
  parameter int ITER_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              ack,
  input  logic [DATA_W-1:0] c_re,
  input  logic [DATA_W-1:0] c_im,
  input  logic [9:0]        px,
  input  logic [9:0]        py,
  input  logic [ITER_W-1:0] max_iter,
  output logic              idle,
  output logic              hold,
  output logic [ITER_W-1:0] result,
  output logic [9:0]        x_tag,
  output logic [9:0]        y_tag
);

  localparam int PW = 2 * DATA_W;
  localparam logic [PW:0] ESC =
    (PW+1)'(ESCAPE_SQ >> PKG_FRAC_W) << FRAC_W;

  lane_state_t state;

  logic signed [DATA_W-1:0] zr, zi, cr, ci;
  logic signed [DATA_W-1:0] zr_n, zi_n;
  logic signed [PW-1:0]     zr_w, zi_w;
  logic signed [PW-1:0]     zr_sq, zi_sq, zr_zi;
  logic        [PW:0]       mag;
  logic        [ITER_W-1:0] iter;
  logic                     escape;

  assign zr_w  = zr;
  assign zi_w  = zi;
  assign zr_sq = (zr_w * zr_w) >>> FRAC_W;
  assign zi_sq = (zi_w * zi_w) >>> FRAC_W;
  assign zr_zi = (zr_w * zi_w) >>> FRAC_W;

  // squares are non-negative, so the widened sum never wraps
  assign mag    = {1'b0, zr_sq} + {1'b0, zi_sq};
  assign escape = mag > ESC;

  assign zr_n = DATA_W'(zr_sq - zi_sq) + cr;
  assign zi_n = DATA_W'(zr_zi <<< 1) + ci;

  assign idle   = (state == L_IDLE);
  assign hold   = (state == L_HOLD);
  assign result = iter;

  // lane sequencing: load, iterate, hold until the arbiter takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= L_IDLE;
      zr    <= '0;
      zi    <= '0;
      cr    <= '0;
      ci    <= '0;
      iter  <= '0;
      x_tag <= '0;
      y_tag <= '0;
    end else begin
      unique case (state)
        L_IDLE: begin
          if (load) begin
            state <= L_ITER;
            zr    <= '0;
            zi    <= '0;
            cr    <= c_re;
            ci    <= c_im;
            iter  <= '0;
            x_tag <= px;
            y_tag <= py;
          end
        end
        L_ITER: begin
          if (escape || iter == max_iter) begin
            state <= L_HOLD;
          end else begin
            zr   <= zr_n;
            zi   <= zi_n;
            iter <= iter + 1'b1;
          end
        end
        L_HOLD: begin
          if (ack) state <= L_IDLE;
        end
        default: state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mandelbrot_multilane.sv
// Frame renderer: raster dispatcher feeding LANES iteration lanes,
// with a lowest-index output arbiter and valid/ready pixel port.
module mandelbrot_multilane
  import mandelbrot_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24,
  parameter int ITER_W = 8,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [DATA_W-1:0] zoom_f,
  input  logic [DATA_W-1:0] re_lower,
  input  logic [DATA_W-1:0] im_upper,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [23:0]       rgb_out,
  output logic [9:0]        x_coord,
  output logic [9:0]        y_coord,
  output logic              busy,
  output logic              frame_done
);

  localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST = 10'(V_RES - 1);

  top_state_t state;

  logic [DATA_W-1:0] zoom_r, re_base, c_re, c_im;
  logic [ITER_W-1:0] iter_lim;
  logic [9:0]        x_cnt, y_cnt;

  logic [LANES-1:0]  lane_idle, lane_hold;
  logic [LANES-1:0]  lane_load, lane_ack;
  logic [LANES-1:0]  out_mask, cand;
  logic [ITER_W-1:0] lane_res [LANES];
  logic [9:0]        lane_x   [LANES];
  logic [9:0]        lane_y   [LANES];

  logic [IDXW-1:0]   disp_idx, pick_idx, out_lane;
  logic              disp_ok, pick_ok, dispatch;
  logic              xfer, load_out, last_xfer, idle_all;

  // lowest idle lane takes the next pixel; lowest holding lane
  // not already in the output register is next to be presented
  always_comb begin
    disp_ok  = 1'b0;
    disp_idx = '0;
    pick_ok  = 1'b0;
    pick_idx = '0;
    out_mask = out_valid ? (LANES'(1) << out_lane) : '0;
    cand     = lane_hold & ~out_mask;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_idle[i]) begin
        disp_ok  = 1'b1;
        disp_idx = IDXW'(i);
      end
      if (cand[i]) begin
        pick_ok  = 1'b1;
        pick_idx = IDXW'(i);
      end
    end
  end

  assign xfer      = out_valid & out_ready;
  assign load_out  = ~out_valid | out_ready;
  assign dispatch  = (state == RUN) & disp_ok;
  assign lane_load = dispatch ? (LANES'(1) << disp_idx) : '0;
  assign lane_ack  = xfer ? out_mask : '0;
  assign idle_all  = (&lane_idle) & ~out_valid;
  assign last_xfer = xfer & ((~lane_idle & ~out_mask) == '0);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mandelbrot_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ITER_W (ITER_W)
    ) u_lane (
      .clk      (aclk),
      .rst_n    (aresetn),
      .load     (lane_load[g]),
      .ack      (lane_ack[g]),
      .c_re     (c_re),
      .c_im     (c_im),
      .px       (x_cnt),
      .py       (y_cnt),
      .max_iter (iter_lim),
      .idle     (lane_idle[g]),
      .hold     (lane_hold[g]),
      .result   (lane_res[g]),
      .x_tag    (lane_x[g]),
      .y_tag    (lane_y[g])
    );
  end

  // frame sequencing, raster walk and incremental pixel constants
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      zoom_r     <= '0;
      re_base    <= '0;
      c_re       <= '0;
      c_im       <= '0;
      iter_lim   <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          // the done-pulse cycle still belongs to the old frame
          if (start && !frame_done) begin
            state    <= RUN;
            busy     <= 1'b1;
            zoom_r   <= zoom_f;
            re_base  <= re_lower;
            c_re     <= re_lower;
            c_im     <= im_upper;
            iter_lim <= (max_iter == '0) ? ITER_W'(1) : max_iter;
            x_cnt    <= '0;
            y_cnt    <= '0;
          end
        end
        RUN: begin
          if (dispatch) begin
            if (x_cnt == X_LAST) begin
              x_cnt <= '0;
              c_re  <= re_base;
              c_im  <= c_im - zoom_r;
              if (y_cnt == Y_LAST) state <= DRAIN;
              else y_cnt <= y_cnt + 1'b1;
            end else begin
              x_cnt <= x_cnt + 1'b1;
              c_re  <= c_re + zoom_r;
            end
          end
        end
        DRAIN: begin
          if (last_xfer || idle_all) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output register: holds while stalled, refills on transfer
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      rgb_out   <= '0;
      x_coord   <= '0;
      y_coord   <= '0;
      out_lane  <= '0;
    end else if (load_out) begin
      out_valid <= pick_ok;
      if (pick_ok) begin
        rgb_out  <= colour_map(8'(lane_res[pick_idx]),
                               lane_res[pick_idx] == iter_lim);
        x_coord  <= lane_x[pick_idx];
        y_coord  <= lane_y[pick_idx];
        out_lane <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_multilane.sv
// Self-checking bench for mandelbrot_multilane on a 4x2 frame,
// compared against a plain-arithmetic escape-time model.
module tb_mandelbrot_multilane;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 24;
  localparam int ITER_W = 8;
  localparam int H_RES  = 4;
  localparam int V_RES  = 2;
  localparam int NPIX   = H_RES * V_RES;
  localparam int BUDGET = 3000;
  localparam int ONE    = 1 << FRAC_W;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] zoom_f = '0;
  logic [31:0] re_lower = '0;
  logic [31:0] im_upper = '0;
  logic [7:0]  max_iter = '0;
  logic        out_valid;
  logic [23:0] rgb_out;
  logic [9:0]  x_coord, y_coord;
  logic        busy, frame_done;

  int checks = 0;
  int errors = 0;

  int          seen    [NPIX];
  logic [23:0] got_rgb [NPIX];
  int bad_coord, stall_bad, done_cnt, done_cyc;
  int last_xfer_cyc, first_valid_cyc, busy_after, out_after;
  bit timeout;

  always #5 aclk = ~aclk;

  mandelbrot_multilane #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ITER_W (ITER_W),
    .H_RES  (H_RES),
    .V_RES  (V_RES)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .zoom_f     (zoom_f),
    .re_lower   (re_lower),
    .im_upper   (im_upper),
    .max_iter   (max_iter),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .rgb_out    (rgb_out),
    .x_coord    (x_coord),
    .y_coord    (y_coord),
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic logic [23:0] ref_rgb(input int zoom, input int re,
                                          input int im, input int mi,
                                          input int x, input int y);
    int cr, ci, m, zr, zi, it;
    longint a, b, p;
    cr = re + x * zoom;
    ci = im - y * zoom;
    m  = (mi == 0) ? 1 : mi;
    zr = 0;
    zi = 0;
    it = 0;
    while (it < m) begin
      a = (longint'(zr) * longint'(zr)) >>> FRAC_W;
      b = (longint'(zi) * longint'(zi)) >>> FRAC_W;
      if (a + b > (longint'(4) <<< FRAC_W)) break;
      p  = (longint'(zr) * longint'(zi)) >>> FRAC_W;
      zr = int'(a - b) + cr;
      zi = 2 * int'(p) + ci;
      it++;
    end
    if (it == m) return 24'h000000;
    return {it[7:0], ~it[7:0], 8'hFF};
  endfunction

  task automatic run_frame(input int zoom, input int re, input int im,
                           input int mi, input bit rnd,
                           input bit poke_mid, input bit poke_done);
    logic        prev_stall;
    logic [23:0] prev_rgb;
    logic [9:0]  prev_x, prev_y;
    int          p;
    for (int i = 0; i < NPIX; i++) begin
      seen[i]    = 0;
      got_rgb[i] = '0;
    end
    bad_coord = 0; stall_bad = 0; done_cnt = 0;
    done_cyc = -1; last_xfer_cyc = -1; first_valid_cyc = -1;
    busy_after = 0; out_after = 0;
    prev_stall = 1'b0; prev_rgb = '0; prev_x = '0; prev_y = '0;
    @(negedge aclk);
    zoom_f   = zoom;
    re_lower = re;
    im_upper = im;
    max_iter = 8'(mi);
    start    = 1'b1;
    @(negedge aclk);
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      if (cyc > 0) @(negedge aclk);
      start = 1'b0;
      if (poke_mid && cyc == 2) begin
        start    = 1'b1;
        zoom_f   = zoom + ONE / 4;
        re_lower = re + ONE;
        max_iter = 8'(mi + 3);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (!out_valid || rgb_out !== prev_rgb ||
          x_coord !== prev_x || y_coord !== prev_y))
        stall_bad++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          if (poke_done) start = 1'b1;
        end
      end
      if (done_cyc >= 0 && busy) busy_after++;
      if (done_cyc >= 0 && out_valid) out_after++;
      if (out_valid && out_ready) begin
        last_xfer_cyc = cyc;
        if (x_coord >= 10'(H_RES) || y_coord >= 10'(V_RES)) begin
          bad_coord++;
        end else begin
          p = int'(y_coord) * H_RES + int'(x_coord);
          seen[p]++;
          got_rgb[p] = rgb_out;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_rgb   = rgb_out;
      prev_x     = x_coord;
      prev_y     = y_coord;
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
    end
    timeout   = (done_cyc < 0);
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    checks++;
    if ({out_valid, busy, frame_done, rgb_out, x_coord, y_coord} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%b rgb=%h x=%0d y=%0d, required all 0",
               out_valid, busy, frame_done, rgb_out, x_coord, y_coord);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    run_frame(0, 3 * ONE, 0, 16, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL basic_timeout: no frame_done within %0d cycles", BUDGET);
    end
    for (int p = 0; p < NPIX; p++) begin
      checks++;
      if (seen[p] !== 1 || got_rgb[p] !== 24'h01FEFF) begin
        errors++;
        $display("FAIL basic_pixel%0d: seen=%0d rgb=%h, required seen=1 rgb=01feff",
                 p, seen[p], got_rgb[p]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d, required 1", done_cnt);
    end
    checks++;
    if (first_valid_cyc !== 4) begin
      errors++;
      $display("FAIL basic_latency: first valid at %0d, required 4", first_valid_cyc);
    end
    checks++;
    if (done_cyc !== last_xfer_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_timing: done at %0d, required %0d",
               done_cyc, last_xfer_cyc + 1);
    end
    checks++;
    if (busy_after !== 0 || out_after !== 0 || bad_coord !== 0) begin
      errors++;
      $display("FAIL basic_after_done: busy=%0d valid=%0d badxy=%0d, required 0 0 0",
               busy_after, out_after, bad_coord);
    end
  endtask

  task automatic test_inside();
    run_frame(0, 0, 0, 5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timeout || done_cnt !== 1) begin
      errors++;
      $display("FAIL inside_done: timeout=%0d count=%0d, required 0 1", timeout, done_cnt);
    end
    for (int p = 0; p < NPIX; p++) begin
      checks++;
      if (seen[p] !== 1 || got_rgb[p] !== 24'h000000) begin
        errors++;
        $display("FAIL inside_pixel%0d: seen=%0d rgb=%h, required seen=1 rgb=000000",
                 p, seen[p], got_rgb[p]);
      end
    end
    checks++;
    if (first_valid_cyc !== 8) begin
      errors++;
      $display("FAIL inside_latency: first valid at %0d, required 8", first_valid_cyc);
    end
  endtask

  task automatic test_max_iter_zero();
    int zoom, re, im;
    zoom = ONE / 4;
    re   = -2 * ONE;
    im   = ONE / 2;
    run_frame(zoom, re, im, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (timeout || done_cnt !== 1) begin
      errors++;
      $display("FAIL mi0_done: timeout=%0d count=%0d, required 0 1", timeout, done_cnt);
    end
    for (int p = 0; p < NPIX; p++) begin
      checks++;
      if (seen[p] !== 1 ||
          got_rgb[p] !== ref_rgb(zoom, re, im, 0, p % H_RES, p / H_RES)) begin
        errors++;
        $display("FAIL mi0_pixel%0d: seen=%0d rgb=%h, required seen=1 rgb=%h",
                 p, seen[p], got_rgb[p],
                 ref_rgb(zoom, re, im, 0, p % H_RES, p / H_RES));
      end
    end
    checks++;
    if (first_valid_cyc !== 4) begin
      errors++;
      $display("FAIL mi0_latency: first valid at %0d, required 4", first_valid_cyc);
    end
  endtask

  task automatic test_random_stall();
    int zoom, re, im, mi;
    for (int f = 0; f < 4; f++) begin
      zoom = int'($urandom_range(ONE / 8, ONE / 2));
      re   = -2 * ONE + int'($urandom_range(0, 3 * ONE / 2));
      im   = int'($urandom_range(0, ONE));
      mi   = int'($urandom_range(1, 40));
      run_frame(zoom, re, im, mi, 1'b1, 1'b0, 1'b0);
      checks++;
      if (timeout || done_cnt !== 1) begin
        errors++;
        $display("FAIL rand%0d_done: timeout=%0d count=%0d, required 0 1",
                 f, timeout, done_cnt);
      end
      for (int p = 0; p < NPIX; p++) begin
        checks++;
        if (seen[p] !== 1 ||
            got_rgb[p] !== ref_rgb(zoom, re, im, mi, p % H_RES, p / H_RES)) begin
          errors++;
          $display("FAIL rand%0d_pixel%0d: seen=%0d rgb=%h, required seen=1 rgb=%h",
                   f, p, seen[p], got_rgb[p],
                   ref_rgb(zoom, re, im, mi, p % H_RES, p / H_RES));
        end
      end
      checks++;
      if (stall_bad !== 0 || bad_coord !== 0) begin
        errors++;
        $display("FAIL rand%0d_stall: unstable=%0d badxy=%0d, required 0 0",
                 f, stall_bad, bad_coord);
      end
    end
  endtask

  task automatic test_start_ignored();
    int zoom, re, im, mi;
    zoom = ONE / 4;
    re   = -3 * ONE / 2;
    im   = ONE / 2;
    mi   = 20;
    run_frame(zoom, re, im, mi, 1'b0, 1'b1, 1'b1);
    checks++;
    if (timeout || done_cnt !== 1) begin
      errors++;
      $display("FAIL ignore_done: timeout=%0d count=%0d, required 0 1", timeout, done_cnt);
    end
    for (int p = 0; p < NPIX; p++) begin
      checks++;
      if (seen[p] !== 1 ||
          got_rgb[p] !== ref_rgb(zoom, re, im, mi, p % H_RES, p / H_RES)) begin
        errors++;
        $display("FAIL ignore_pixel%0d: seen=%0d rgb=%h, required seen=1 rgb=%h",
                 p, seen[p], got_rgb[p],
                 ref_rgb(zoom, re, im, mi, p % H_RES, p / H_RES));
      end
    end
    checks++;
    if (busy_after !== 0 || out_after !== 0) begin
      errors++;
      $display("FAIL ignore_start_at_done: busy=%0d valid=%0d, required 0 0",
               busy_after, out_after);
    end
  endtask

  task automatic test_reset_mid_run();
    int waited, junk, zoom, re, im, mi;
    out_ready = 1'b0;
    @(negedge aclk);
    zoom_f   = '0;
    re_lower = 3 * ONE;
    im_upper = '0;
    max_iter = 8'd16;
    start    = 1'b1;
    @(negedge aclk);
    start  = 1'b0;
    waited = 0;
    while (!out_valid && waited < 50) begin
      @(negedge aclk);
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: valid=%b busy=%b, required 1 1", out_valid, busy);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, frame_done, rgb_out, x_coord, y_coord} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: v=%b b=%b d=%b rgb=%h x=%0d y=%0d, required all 0",
               out_valid, busy, frame_done, rgb_out, x_coord, y_coord);
    end
    @(negedge aclk);
    @(negedge aclk);
    aresetn   = 1'b1;
    out_ready = 1'b1;
    junk = 0;
    repeat (10) begin
      @(negedge aclk);
      if (out_valid || busy || frame_done) junk++;
    end
    checks++;
    if (junk !== 0) begin
      errors++;
      $display("FAIL rst_mid_residue: %0d active cycles, required 0", junk);
    end
    zoom = ONE / 8;
    re   = -ONE;
    im   = ONE / 4;
    mi   = 12;
    run_frame(zoom, re, im, mi, 1'b1, 1'b0, 1'b0);
    checks++;
    if (timeout || done_cnt !== 1) begin
      errors++;
      $display("FAIL rst_mid_frame_done: timeout=%0d count=%0d, required 0 1",
               timeout, done_cnt);
    end
    for (int p = 0; p < NPIX; p++) begin
      checks++;
      if (seen[p] !== 1 ||
          got_rgb[p] !== ref_rgb(zoom, re, im, mi, p % H_RES, p / H_RES)) begin
        errors++;
        $display("FAIL rst_mid_pixel%0d: seen=%0d rgb=%h, required seen=1 rgb=%h",
                 p, seen[p], got_rgb[p],
                 ref_rgb(zoom, re, im, mi, p % H_RES, p / H_RES));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inside();
    test_max_iter_zero();
    test_random_stall();
    test_start_ignored();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
